// File: rtl/bbc_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : bbc_framebuffer_scanout
// Description : Raster scan-out engine for the BBC framebuffer SRAM. Walks a
//               counter-driven 640x512 timing grid, reads one 48-bit word
//               (16 pixels x 3 bits) per 16 active pixels through SRAM
//               port 1, and expands 3-bit BBC colour to 24-bit RGB with
//               optional line doubling.
// Ports       : clk, reset_n (sync, active low)
//               enable, fb_base        - sampled only at frame start
//               sram_select/address    - port-1 read request
//               sram_read_data         - valid the cycle after sram_select
//               video_de/hsync/vsync   - timing, 2 clocks after counters
//               video_red/green/blue   - pixel colour, zero outside de
// Revision    : 1.0 - initial release
// ============================================================================
module bbc_framebuffer_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 512,
    parameter int V_FP        = 1,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 28,
    parameter int LINE_DOUBLE = 1,
    parameter int SYNC_ACT_HI = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [13:0] fb_base,
    output logic        sram_select,
    output logic [13:0] sram_address,
    input  logic [47:0] sram_read_data,
    output logic        video_de,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic [7:0]  video_red,
    output logic [7:0]  video_green,
    output logic [7:0]  video_blue
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_H_ACT_LAST = c_HW'(H_ACTIVE - 1);
    localparam logic [c_HW-1:0] c_H_SS       = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_H_SE       = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_V_SS       = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_V_SE       = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [13:0]     c_LINE_STEP  = 14'(H_ACTIVE / 16);
    // Output level of an idle sync line: high for active-low syncs.
    localparam logic            c_SYNC_IDLE  = (SYNC_ACT_HI != 0) ? 1'b0 : 1'b1;

    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;
    logic            r_frame_en;
    logic [13:0]     r_line_addr;
    logic [47:0]     r_shift;
    logic            r_s2_load;
    logic            r_s2_de;
    logic            r_s2_hs;
    logic            r_s2_vs;

    logic [c_HW-1:0] w_h_nxt;
    logic [c_VW-1:0] w_v_nxt;
    logic            w_frame_wrap;
    logic            w_line_adv;
    logic            w_fe_nxt;
    logic [13:0]     w_la_nxt;
    logic            w_fetch_nxt;
    logic [47:0]     w_word;

    always_comb begin
        w_h_nxt      = (r_h == c_H_LAST) ? '0 : r_h + 1'b1;
        w_v_nxt      = r_v;
        if (r_h == c_H_LAST) begin
            w_v_nxt = (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end
        w_frame_wrap = (r_h == c_H_LAST) && (r_v == c_V_LAST);
        // With doubling, the address only moves on after the odd line.
        w_line_adv   = (r_h == c_H_ACT_LAST) && (r_v < c_V_ACT) &&
                       ((LINE_DOUBLE == 0) || r_v[0]);

        // Frame-start latches take effect in the same edge that moves the
        // counters to h=v=0, so the first fetch of a frame already sees them.
        w_fe_nxt     = w_frame_wrap ? enable : r_frame_en;
        w_la_nxt     = r_line_addr;
        if (w_frame_wrap) begin
            w_la_nxt = fb_base;
        end else if (w_line_adv) begin
            w_la_nxt = r_line_addr + c_LINE_STEP;
        end

        // The read strobe is registered from the next counter values so it
        // coincides with the counter value it belongs to; the data then lands
        // one cycle later, giving the two-clock pixel latency.
        w_fetch_nxt  = w_fe_nxt && (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT) &&
                       (w_h_nxt[3:0] == 4'd0);

        w_word       = r_s2_load ? sram_read_data : r_shift;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_h          <= '0;
            r_v          <= '0;
            r_frame_en   <= 1'b0;
            r_line_addr  <= '0;
            r_shift      <= '0;
            r_s2_load    <= 1'b0;
            r_s2_de      <= 1'b0;
            r_s2_hs      <= 1'b0;
            r_s2_vs      <= 1'b0;
            sram_select  <= 1'b0;
            sram_address <= '0;
            video_de     <= 1'b0;
            video_hsync  <= c_SYNC_IDLE;
            video_vsync  <= c_SYNC_IDLE;
            video_red    <= '0;
            video_green  <= '0;
            video_blue   <= '0;
        end else begin
            r_h          <= w_h_nxt;
            r_v          <= w_v_nxt;
            r_frame_en   <= w_fe_nxt;
            r_line_addr  <= w_la_nxt;

            sram_select  <= w_fetch_nxt;
            sram_address <= w_la_nxt + 14'(w_h_nxt[c_HW-1:4]);

            // Stage 2: timing flags for the current counter value, waiting
            // alongside the SRAM access.
            r_s2_load    <= (r_h[3:0] == 4'd0);
            r_s2_de      <= r_frame_en && (r_h < c_H_ACT) && (r_v < c_V_ACT);
            r_s2_hs      <= (r_h >= c_H_SS) && (r_h < c_H_SE);
            r_s2_vs      <= (r_v >= c_V_SS) && (r_v < c_V_SE);

            r_shift      <= w_word >> 3;
            video_de     <= r_s2_de;
            video_hsync  <= r_s2_hs ^ c_SYNC_IDLE;
            video_vsync  <= r_s2_vs ^ c_SYNC_IDLE;
            video_red    <= {8{w_word[0] & r_s2_de}};
            video_green  <= {8{w_word[1] & r_s2_de}};
            video_blue   <= {8{w_word[2] & r_s2_de}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bbc_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_bbc_framebuffer_scanout
// Description : Self-checking bench for bbc_framebuffer_scanout. Two
//               instances (line-doubled/active-low, single/active-high) run
//               on a shrunken raster against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bbc_framebuffer_scanout;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int NF = 5;

    typedef struct {
        bit          en;
        logic [13:0] base;
        int          exp_sel;
    } frm_t;

    typedef struct {
        bit          sel;
        logic [13:0] addr;
        bit          de;
        bit          hs;
        bit          vs;
        logic [23:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [13:0] fb_base = '0;

    logic        sel   [2];
    logic [13:0] addr  [2];
    logic [47:0] rdata [2];
    logic        de    [2];
    logic        hs    [2];
    logic        vs    [2];
    logic [7:0]  red   [2];
    logic [7:0]  green [2];
    logic [7:0]  blue  [2];

    logic [47:0] mem [16384];
    frm_t        frm [NF];
    logic [23:0] col_tbl [8];

    int          k = 0;
    bit          was_rst = 1'b0;
    bit          armed = 1'b0;
    bit          fen   [16];
    logic [13:0] fbase [16];
    int          sel_cnt [2];
    int          nf_run = 0;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        ms, mv;

    always #5 clk = ~clk;

    bbc_framebuffer_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LINE_DOUBLE(1), .SYNC_ACT_HI(0)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fb_base(fb_base),
        .sram_select(sel[0]), .sram_address(addr[0]), .sram_read_data(rdata[0]),
        .video_de(de[0]), .video_hsync(hs[0]), .video_vsync(vs[0]),
        .video_red(red[0]), .video_green(green[0]), .video_blue(blue[0])
    );

    bbc_framebuffer_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .LINE_DOUBLE(0), .SYNC_ACT_HI(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .fb_base(fb_base),
        .sram_select(sel[1]), .sram_address(addr[1]), .sram_read_data(rdata[1]),
        .video_de(de[1]), .video_hsync(hs[1]), .video_vsync(vs[1]),
        .video_red(red[1]), .video_green(green[1]), .video_blue(blue[1])
    );

    // SRAM port 1: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (sel[0]) rdata[0] <= mem[addr[0]];
        if (sel[1]) rdata[1] <= mem[addr[1]];
    end

    // Clocks since reset release, plus the enable/base seen at each frame start.
    always @(posedge clk) begin
        if (!reset_n) begin
            k       <= 0;
            was_rst <= 1'b1;
            armed   <= 1'b1;
        end else begin
            k       <= k + 1;
            was_rst <= 1'b0;
            if ((k + 1) % FT == 0) begin
                fen[(k + 1) / FT]   <= enable;
                fbase[(k + 1) / FT] <= fb_base;
            end
        end
    end

    // Expected outputs for raster position n (clocks since release).
    function automatic exp_t model(input int n, input bit ld, input bit pol);
        exp_t        e;
        int          h, v, f, line;
        bit          en;
        logic [13:0] a;
        logic [47:0] w;
        logic [2:0]  p;
        e.sel = 1'b0; e.addr = '0; e.de = 1'b0; e.rgb = '0;
        e.hs  = !pol; e.vs = !pol;
        if (n < 0) return e;
        h  = n % HT;
        v  = (n / HT) % VT;
        f  = n / FT;
        en = (f >= 1) && fen[f];
        if (h >= HA + HF && h < HA + HF + HS) e.hs = pol;
        if (v >= VA + VF && v < VA + VF + VS) e.vs = pol;
        if (en && h < HA && v < VA) begin
            line   = ld ? v / 2 : v;
            a      = 14'((int'(fbase[f]) + line * (HA / 16) + h / 16) % 16384);
            e.de   = 1'b1;
            e.sel  = (h % 16 == 0);
            e.addr = a;
            w      = mem[a];
            p      = w[3 * (h % 16) +: 3];
            e.rgb  = {p[0] ? 8'hFF : 8'h00, p[1] ? 8'hFF : 8'h00, p[2] ? 8'hFF : 8'h00};
        end
        return e;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d k=%0d: got %0h, expected %0h", name, i, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (was_rst) begin
                chk("rst_sel",  i, 32'(sel[i]), 0);
                chk("rst_addr", i, 32'(addr[i]), 0);
                chk("rst_de",   i, 32'(de[i]), 0);
                chk("rst_rgb",  i, {8'h0, red[i], green[i], blue[i]}, 0);
                chk("rst_sync", i, {30'h0, hs[i], vs[i]}, (i == 0) ? 32'h3 : 32'h0);
                sel_cnt[i] = 0;
            end else if (armed) begin
                ms = model(k, i == 0, i == 1);
                mv = model(k - 2, i == 0, i == 1);
                chk("sel", i, 32'(sel[i]), 32'(ms.sel));
                if (ms.sel) chk("addr", i, 32'(addr[i]), 32'(ms.addr));
                chk("de",    i, 32'(de[i]), 32'(mv.de));
                chk("hsync", i, 32'(hs[i]), 32'(mv.hs));
                chk("vsync", i, 32'(vs[i]), 32'(mv.vs));
                chk("rgb",   i, {8'h0, red[i], green[i], blue[i]}, {8'h0, mv.rgb});
                if (k >= 2 && (k - 2) / FT == 1 && ((k - 2) / HT) % VT == 0 && (k - 2) % HT < 8)
                    chk("colour", i, {8'h0, red[i], green[i], blue[i]},
                        {8'h0, col_tbl[(k - 2) % HT]});
                if (sel[i]) sel_cnt[i]++;
                if (k % FT == FT - 1) begin
                    chk("frame_selects", i, 32'(sel_cnt[i]),
                        (k / FT >= 1 && k / FT <= nf_run) ? 32'(frm[k / FT - 1].exp_sel) : 0);
                    sel_cnt[i] = 0;
                end
            end
        end
    end

    // Frame starts get the table values; every other cycle gets noise so
    // mid-frame changes to enable/fb_base are exercised continuously.
    task automatic run(input int nf, input int stop_k);
        nf_run = nf;
        while (k < stop_k) begin
            @(negedge clk);
            if ((k + 1) % FT == 0 && (k + 1) / FT >= 1 && (k + 1) / FT <= nf) begin
                enable  = frm[(k + 1) / FT - 1].en;
                fb_base = frm[(k + 1) / FT - 1].base;
            end else begin
                enable  = 1'($urandom_range(0, 1));
                fb_base = 14'($urandom);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = {16'($urandom), 32'($urandom)};
        mem[0]   = 48'o7654321076543210;
        rdata[0] = '0;
        rdata[1] = '0;
        frm[0] = '{1'b1, 14'd0,           VA * HA / 16};
        frm[1] = '{1'b1, 14'd16382,       VA * HA / 16};
        frm[2] = '{1'b0, 14'd5,           0};
        frm[3] = '{1'b1, 14'($urandom),   VA * HA / 16};
        frm[4] = '{1'b1, 14'd9000,        VA * HA / 16};
        col_tbl[0] = 24'h000000; col_tbl[1] = 24'hFF0000;
        col_tbl[2] = 24'h00FF00; col_tbl[3] = 24'hFFFF00;
        col_tbl[4] = 24'h0000FF; col_tbl[5] = 24'hFF00FF;
        col_tbl[6] = 24'h00FFFF; col_tbl[7] = 24'hFFFFFF;

        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run(NF, NF * FT + 3 * HT + 20);

        // Reset in the middle of an active line of an enabled frame.
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run(2, 3 * FT + 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
